// File: rtl/add_norm_round.sv
// add_norm_round: normalize / round / pack stage that sits directly behind the
// binary64 adder. Three register stages with a valid/ready chain:
//   stage 1 holds the normalized significand and exponent,
//   stage 2 holds the rounded significand,
//   stage 3 holds the packed IEEE double and its exception flags.
// Each stage loads when it is empty or when the stage after it is advancing,
// so the pipe keeps one beat per cycle and holds at most three beats under
// backpressure.
module add_norm_round (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [10:0] es,
  input  logic [56:0] fs,
  input  logic        ss,
  input  logic [57:0] fls,
  input  logic [1:0]  RM,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] result,
  output logic        ovf,
  output logic        unf,
  output logic        inx,
  output logic        inv
);

  localparam logic [1:0] RM_RNE = 2'b00;
  localparam logic [1:0] RM_RZ  = 2'b01;
  localparam logic [1:0] RM_RU  = 2'b10;
  localparam logic [1:0] RM_RD  = 2'b11;

  localparam logic [12:0] E_OVF = 13'd2047;

  // ---------------------------------------------------------------------------
  // Handshake chain
  // ---------------------------------------------------------------------------
  logic v1, v2, v3;
  logic en1, en2, en3;

  assign en3       = ~v3 | out_ready;
  assign en2       = ~v2 | en3;
  assign en1       = ~v1 | en2;
  assign in_ready  = en1;
  assign out_valid = v3;

  // fls[57] is spare and fls[52:51] are replaced by the forced quiet bit.
  logic unused_fls;
  assign unused_fls = ^{fls[57], fls[52:51]};

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: normalize the raw sum
  // ---------------------------------------------------------------------------
  logic [12:0] n_ebase;
  logic [5:0]  n_lz;
  logic [12:0] n_lz13;
  logic [12:0] n_shmax;
  logic [12:0] n_sh13;
  logic [55:0] n_sig;
  logic [12:0] n_e;
  logic        n_zero;

  // Leading-zero count over fs[55:0]; the highest set bit wins, 56 when empty.
  always_comb begin
    n_lz = 6'd56;
    for (int i = 0; i < 56; i++) begin
      if (fs[i]) n_lz = 6'(55 - i);
    end
  end

  // Carry: shift right one and fold old R|S into sticky. Otherwise shift left
  // by the leading-zero count, but never below exponent 1 (denormal floor).
  always_comb begin
    n_ebase = (es == 11'd0) ? 13'd1 : {2'b00, es};
    n_lz13  = {7'd0, n_lz};
    n_shmax = n_ebase - 13'd1;
    n_sh13  = (n_lz13 < n_shmax) ? n_lz13 : n_shmax;
    if (fs[56]) begin
      n_sig = {fs[56:2], fs[1] | fs[0]};
      n_e   = n_ebase + 13'd1;
    end else begin
      n_sig = fs[55:0] << n_sh13[5:0];
      n_e   = n_ebase - n_sh13;
    end
    n_zero = fls[56] | (fs == 57'd0);
  end

  logic [55:0] s1_sig;
  logic [12:0] s1_e;
  logic        s1_ss;
  logic [1:0]  s1_rm;
  logic        s1_zero, s1_inv, s1_infs, s1_nans;
  logic [50:0] s1_nan;

  // Stage 1 register: normalized value plus the sideband that rides with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      v1      <= 1'b0;
      s1_sig  <= '0;
      s1_e    <= '0;
      s1_ss   <= 1'b0;
      s1_rm   <= '0;
      s1_zero <= 1'b0;
      s1_inv  <= 1'b0;
      s1_infs <= 1'b0;
      s1_nans <= 1'b0;
      s1_nan  <= '0;
    end else if (en1) begin
      v1      <= in_valid;
      s1_sig  <= n_sig;
      s1_e    <= n_e;
      s1_ss   <= ss;
      s1_rm   <= RM;
      s1_zero <= n_zero;
      s1_inv  <= fls[55];
      s1_infs <= fls[54];
      s1_nans <= fls[53];
      s1_nan  <= fls[50:0];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: round
  // ---------------------------------------------------------------------------
  logic        r_l, r_g, r_r, r_s, r_grs, r_inc;
  logic [53:0] r_sum;
  logic [52:0] r_sig;
  logic [12:0] r_e;

  // Increment decision per rounding mode, then add into the 53-bit significand.
  // A denormal that rounds into bit 52 already carries exponent 1 from the
  // normalize floor, so it needs no exponent fix-up here.
  always_comb begin
    r_l   = s1_sig[3];
    r_g   = s1_sig[2];
    r_r   = s1_sig[1];
    r_s   = s1_sig[0];
    r_grs = r_g | r_r | r_s;
    case (s1_rm)
      RM_RNE:  r_inc = r_g & (r_r | r_s | r_l);
      RM_RZ:   r_inc = 1'b0;
      RM_RU:   r_inc = ~s1_ss & r_grs;
      RM_RD:   r_inc = s1_ss & r_grs;
      default: r_inc = 1'b0;
    endcase
    r_sum = {1'b0, s1_sig[55:3]} + {53'd0, r_inc};
    if (r_sum[53]) begin
      r_sig = r_sum[53:1];
      r_e   = s1_e + 13'd1;
    end else begin
      r_sig = r_sum[52:0];
      r_e   = s1_e;
    end
  end

  logic [52:0] s2_sig;
  logic [12:0] s2_e;
  logic        s2_inx;
  logic        s2_ss;
  logic [1:0]  s2_rm;
  logic        s2_zero, s2_inv, s2_infs, s2_nans;
  logic [50:0] s2_nan;

  // Stage 2 register: rounded significand and exponent.
  always_ff @(posedge clk) begin
    if (reset) begin
      v2      <= 1'b0;
      s2_sig  <= '0;
      s2_e    <= '0;
      s2_inx  <= 1'b0;
      s2_ss   <= 1'b0;
      s2_rm   <= '0;
      s2_zero <= 1'b0;
      s2_inv  <= 1'b0;
      s2_infs <= 1'b0;
      s2_nans <= 1'b0;
      s2_nan  <= '0;
    end else if (en2) begin
      v2      <= v1;
      s2_sig  <= r_sig;
      s2_e    <= r_e;
      s2_inx  <= r_grs;
      s2_ss   <= s1_ss;
      s2_rm   <= s1_rm;
      s2_zero <= s1_zero;
      s2_inv  <= s1_inv;
      s2_infs <= s1_infs;
      s2_nans <= s1_nans;
      s2_nan  <= s1_nan;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3 combinational: pack, overflow, specials
  // ---------------------------------------------------------------------------
  logic [63:0] p_res;
  logic        p_ovf, p_unf, p_inx, p_to_inf;
  logic [10:0] p_exp;

  // Specials take priority NaN > Inf > Zero and suppress arithmetic flags.
  // Overflow saturates to inf or the largest finite value depending on
  // whether the rounding direction points away from zero.
  always_comb begin
    p_res    = '0;
    p_ovf    = 1'b0;
    p_unf    = 1'b0;
    p_inx    = 1'b0;
    p_exp    = '0;
    p_to_inf = (s2_rm == RM_RNE) | ((s2_rm == RM_RU) & ~s2_ss) |
               ((s2_rm == RM_RD) & s2_ss);
    if (s2_nans) begin
      p_res = {s2_ss, 11'h7FF, 1'b1, s2_nan};
    end else if (s2_infs) begin
      p_res = {s2_ss, 11'h7FF, 52'd0};
    end else if (s2_zero) begin
      p_res = {s2_ss, 63'd0};
    end else if (s2_e >= E_OVF) begin
      p_ovf = 1'b1;
      p_inx = 1'b1;
      p_res = p_to_inf ? {s2_ss, 11'h7FF, 52'd0}
                       : {s2_ss, 11'h7FE, {52{1'b1}}};
    end else begin
      p_exp = s2_sig[52] ? s2_e[10:0] : 11'd0;
      p_res = {s2_ss, p_exp, s2_sig[51:0]};
      p_inx = s2_inx;
      p_unf = ~s2_sig[52] & s2_inx;
    end
  end

  // Stage 3 register: the visible result; frozen while out_valid & ~out_ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      v3     <= 1'b0;
      result <= '0;
      ovf    <= 1'b0;
      unf    <= 1'b0;
      inx    <= 1'b0;
      inv    <= 1'b0;
    end else if (en3) begin
      v3     <= v2;
      result <= p_res;
      ovf    <= p_ovf;
      unf    <= p_unf;
      inx    <= p_inx;
      inv    <= s2_inv;
    end
  end

endmodule

// File: tb/tb_add_norm_round.sv
// tb_add_norm_round: directed vectors with hand-computed binary64 results,
// plus short sequences for backpressure and reset with beats in flight.
module tb_add_norm_round;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [10:0] es;
  logic [56:0] fs;
  logic        ss;
  logic [57:0] fls;
  logic [1:0]  RM;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        ovf, unf, inx, inv;

  add_norm_round dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .es(es), .fs(fs), .ss(ss), .fls(fls), .RM(RM),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .ovf(ovf), .unf(unf), .inx(inx), .inv(inv)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [10:0] es;
    logic [56:0] fs;
    logic        ss;
    logic [57:0] fls;
    logic [1:0]  rm;
    logic [63:0] res;
    logic        ovf;
    logic        unf;
    logic        inx;
    logic        inv;
    logic        unf_dc;
  } vec_t;

  localparam logic [56:0] F_ALL = {1'b0, {54{1'b1}}, 2'b00};
  localparam logic [56:0] F_DEN = {2'b00, {53{1'b1}}, 2'b00};
  localparam logic [57:0] L_ZERO = 58'd1 << 56;
  localparam logic [57:0] L_INV  = 58'd1 << 55;
  localparam logic [57:0] L_INF  = 58'd1 << 54;
  localparam logic [57:0] L_NAN  = 58'd1 << 53;
  localparam logic [63:0] MAXF   = 64'h7FEFFFFFFFFFFFFF;

  int checks = 0;
  int errors = 0;
  vec_t vecs[$];

  function automatic vec_t mk(logic [10:0] e, logic [56:0] f, logic s,
                              logic [57:0] fl, logic [1:0] rm, logic [63:0] r,
                              logic o, logic u, logic x, logic iv, logic udc);
    vec_t v;
    v.es = e; v.fs = f; v.ss = s; v.fls = fl; v.rm = rm; v.res = r;
    v.ovf = o; v.unf = u; v.inx = x; v.inv = iv; v.unf_dc = udc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input vec_t v);
    es = v.es; fs = v.fs; ss = v.ss; fls = v.fls; RM = v.rm;
  endtask

  task automatic chk_out(input string tag, input vec_t v);
    chk({tag, ".result"}, result, v.res);
    chk({tag, ".ovf"}, 64'(ovf), 64'(v.ovf));
    if (!v.unf_dc) chk({tag, ".unf"}, 64'(unf), 64'(v.unf));
    chk({tag, ".inx"}, 64'(inx), 64'(v.inx));
    chk({tag, ".inv"}, 64'(inv), 64'(v.inv));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    int n;
    int seen;
    vec_t z;

    //            es     fs                               ss  fls            rm     result                 o  u  x  i  udc
    vecs.push_back(mk(1023, 57'd1 << 56,                   0, '0,            2'b00, 64'h4000000000000000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1023, 57'd1 << 3,                    0, '0,            2'b00, 64'h3CB0000000000000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1023, (57'd1 << 55) | (57'd1 << 2),  0, '0,            2'b00, 64'h3FF0000000000000, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1023, (57'd1 << 55) | (57'd3 << 2),  0, '0,            2'b00, 64'h3FF0000000000002, 0, 0, 1, 0, 0));
    vecs.push_back(mk(2046, F_ALL,                         0, '0,            2'b00, 64'h7FF0000000000000, 1, 0, 1, 0, 0));
    vecs.push_back(mk(2046, F_ALL,                         0, '0,            2'b01, MAXF,                 0, 0, 1, 0, 0));
    vecs.push_back(mk(2046, F_ALL,                         0, '0,            2'b11, MAXF,                 0, 0, 1, 0, 0));
    vecs.push_back(mk(2047, 57'd1 << 56,                   0, '0,            2'b01, MAXF,                 1, 0, 1, 0, 0));
    vecs.push_back(mk(2047, 57'd1 << 56,                   1, '0,            2'b11, 64'hFFF0000000000000, 1, 0, 1, 0, 0));
    vecs.push_back(mk(2047, 57'd1 << 56,                   1, '0,            2'b10, 64'hFFEFFFFFFFFFFFFF, 1, 0, 1, 0, 0));
    vecs.push_back(mk(1023, (57'd1 << 55) | 57'd1,         0, '0,            2'b10, 64'h3FF0000000000001, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1023, (57'd1 << 55) | 57'd1,         1, '0,            2'b11, 64'hBFF0000000000001, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1023, (57'd1 << 55) | 57'd1,         0, '0,            2'b11, 64'h3FF0000000000000, 0, 0, 1, 0, 0));
    vecs.push_back(mk(1023, (57'd1 << 55) | 57'd1,         1, '0,            2'b01, 64'hBFF0000000000000, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0,    57'd1 << 3,                    0, '0,            2'b00, 64'h0000000000000001, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0,    (57'd1 << 3) | 57'd1,          0, '0,            2'b00, 64'h0000000000000001, 0, 1, 1, 0, 0));
    vecs.push_back(mk(10,   57'd1 << 3,                    0, '0,            2'b00, 64'h0000000000000200, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1,    F_DEN,                         0, '0,            2'b00, 64'h0010000000000000, 0, 0, 1, 0, 1));
    vecs.push_back(mk(500,  57'd0,                         1, '0,            2'b00, 64'h8000000000000000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1023, 57'd1 << 55,                   0, L_ZERO,        2'b00, 64'h0000000000000000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1023, 57'd1 << 55,                   0, L_NAN,         2'b00, 64'h7FF8000000000000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1023, 57'd1 << 55,                   0, L_NAN | L_INV, 2'b00, 64'h7FF8000000000000, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1023, 57'd1 << 55,                   1, L_INF,         2'b00, 64'hFFF0000000000000, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1023, F_ALL,                         0, L_NAN | L_INF | 58'h12345, 2'b00, 64'h7FF8000000012345, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1023, F_ALL,                         0, L_INF | L_ZERO, 2'b00, 64'h7FF0000000000000, 0, 0, 0, 0, 0));

    z = mk(0, '0, 0, '0, 2'b00, '0, 0, 0, 0, 0, 0);
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(z);
    tick(); tick(); tick();
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.result", result, 64'd0);
    chk("rst.flags", 64'({ovf, unf, inx, inv}), 64'd0);
    chk("rst.in_ready", 64'(in_ready), 64'd1);
    reset = 1'b0;
    tick();

    // One beat at a time: latency and value per vector.
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 10) begin
        tick();
        n++;
      end
      chk($sformatf("v%0d.latency", i), 64'(n), 64'd3);
      chk_out($sformatf("v%0d", i), vecs[i]);
      tick();
    end

    // Backpressure: three beats fill the pipe, the fourth waits.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(vecs[i]);
      in_valid = 1'b1;
      chk($sformatf("bp.in_ready%0d", i), 64'(in_ready), 64'd1);
      tick();
    end
    drive(vecs[3]);
    chk("bp.in_ready_drop", 64'(in_ready), 64'd0);
    chk("bp.out_valid", 64'(out_valid), 64'd1);
    chk("bp.head", result, vecs[0].res);
    tick(); tick();
    chk("bp.hold_valid", 64'(out_valid), 64'd1);
    chk("bp.hold_result", result, vecs[0].res);
    chk("bp.hold_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("bp.drain_valid%0d", k), 64'(out_valid), 64'd1);
      chk($sformatf("bp.drain_result%0d", k), result, vecs[k].res);
      tick();
      in_valid = 1'b0;
    end
    chk("bp.empty", 64'(out_valid), 64'd0);

    // Reset with two beats in flight discards them.
    drive(vecs[0]);
    in_valid = 1'b1;
    tick();
    drive(vecs[2]);
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    chk("rst2.out_valid", 64'(out_valid), 64'd0);
    chk("rst2.result", result, 64'd0);
    reset = 1'b0;
    seen = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (out_valid) seen++;
    end
    chk("rst2.no_emit", 64'(seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
